// File: rtl/bus_mnt.sv
// Passive AHB-lite write snooper: console character port, test-status port and a cycle watchdog.
// Never drives or stalls the bus; all outputs are registered one clock after the data phase.
module bus_mnt #(
    parameter logic [31:0] PRINT_ADDR = 32'h6000_FFF8,
    parameter logic [31:0] CTRL_ADDR  = 32'h6000_FFF0,
    parameter logic [31:0] MAX_CYCLES = 32'd60_000_000
) (
    input  logic        i_ext_pad_clkmux_ehs_clk,
    input  logic        PI_SOC_RST_B,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [31:0] haddr,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        char_valid,
    output logic [7:0]  char_data,
    output logic        test_pass,
    output logic        test_fail,
    output logic        test_done,
    output logic        timeout,
    output logic [31:0] wr_count,
    output logic [31:0] cycle_count
);

    logic        ap_valid;
    logic [29:0] ap_addr;
    logic        accept;
    logic        dp_done;
    logic        hit_print;
    logic        hit_ctrl;
    logic        wd_fire;
    logic        unused_bits;

    // hsize, htrans[0] and the byte offset do not affect word-address decode
    assign unused_bits = ^{hsize, htrans[0], haddr[1:0]};

    assign accept    = hsel & htrans[1] & hwrite & hready;
    assign dp_done   = ap_valid & hready;
    assign hit_print = dp_done & (ap_addr == PRINT_ADDR[31:2]);
    assign hit_ctrl  = dp_done & (ap_addr == CTRL_ADDR[31:2]);
    assign wd_fire   = (MAX_CYCLES != '0) && (cycle_count == MAX_CYCLES - 32'd1) && !test_done;
    assign test_done = test_pass | test_fail;

    // Address phase: a stalled bus (hready=0) freezes the pending transfer
    always_ff @(posedge i_ext_pad_clkmux_ehs_clk or posedge PI_SOC_RST_B) begin
        if (PI_SOC_RST_B) begin
            ap_valid <= 1'b0;
            ap_addr  <= '0;
        end else if (hready) begin
            ap_valid <= accept;
            if (accept)
                ap_addr <= haddr[31:2];
        end
    end

    always_ff @(posedge i_ext_pad_clkmux_ehs_clk or posedge PI_SOC_RST_B) begin
        if (PI_SOC_RST_B) begin
            char_valid <= 1'b0;
            char_data  <= '0;
            wr_count   <= '0;
        end else begin
            char_valid <= hit_print;
            if (hit_print)
                char_data <= hwdata[7:0];
            if (hit_print || hit_ctrl)
                wr_count <= wr_count + 32'd1;
        end
    end

    always_ff @(posedge i_ext_pad_clkmux_ehs_clk or posedge PI_SOC_RST_B) begin
        if (PI_SOC_RST_B)
            cycle_count <= '0;
        else if (cycle_count != '1)
            cycle_count <= cycle_count + 32'd1;
    end

    // First status write wins; a watchdog expiry in the same cycle still sets fail
    always_ff @(posedge i_ext_pad_clkmux_ehs_clk or posedge PI_SOC_RST_B) begin
        if (PI_SOC_RST_B) begin
            test_pass <= 1'b0;
            test_fail <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            if (hit_ctrl && !test_done) begin
                if (hwdata == 32'h0000_0001)
                    test_pass <= 1'b1;
                if (hwdata == 32'h0000_0002)
                    test_fail <= 1'b1;
            end
            if (wd_fire) begin
                timeout   <= 1'b1;
                test_fail <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_mnt.sv
// Directed self-checking bench for bus_mnt: console writes, pipelined bursts with stalls,
// status sticky behaviour, ignored transfers, reset mid-transfer and the watchdog.
module tb_bus_mnt;

    localparam logic [31:0] PADDR = 32'h6000_FFF8;
    localparam logic [31:0] CADDR = 32'h6000_FFF0;
    localparam logic [1:0]  IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        test_pass, test_fail, test_done, timeout;
    logic [31:0] wr_count, cycle_count;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;
    logic [31:0] exp_wr = 0;

    always #5 clk = ~clk;

    bus_mnt #(
        .PRINT_ADDR(PADDR),
        .CTRL_ADDR (CADDR),
        .MAX_CYCLES(32'd100)
    ) dut (
        .i_ext_pad_clkmux_ehs_clk(clk),
        .PI_SOC_RST_B(rst),
        .hsel(hsel),
        .htrans(htrans),
        .hwrite(hwrite),
        .haddr(haddr),
        .hsize(hsize),
        .hwdata(hwdata),
        .hready(hready),
        .char_valid(char_valid),
        .char_data(char_data),
        .test_pass(test_pass),
        .test_fail(test_fail),
        .test_done(test_done),
        .timeout(timeout),
        .wr_count(wr_count),
        .cycle_count(cycle_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of bus inputs; returns 1 time unit after the sampling edge
    task automatic step(input logic sel, input logic [1:0] tr, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd, input logic rdy);
        hsel = sel; htrans = tr; hwrite = wr; haddr = a; hwdata = wd; hready = rdy;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input logic [31:0] wd);
        step(1'b0, IDLE, 1'b0, 32'h0, wd, 1'b1);
    endtask

    task automatic chk_status(input string tag, input logic p, input logic f,
                              input logic d, input logic t);
        chk({tag, "_pass"}, {31'b0, test_pass}, {31'b0, p});
        chk({tag, "_fail"}, {31'b0, test_fail}, {31'b0, f});
        chk({tag, "_done"}, {31'b0, test_done}, {31'b0, d});
        chk({tag, "_tmo"},  {31'b0, timeout},   {31'b0, t});
    endtask

    initial begin
        rst = 1'b1; hsel = 0; htrans = IDLE; hwrite = 0; haddr = 0;
        hsize = 3'b010; hwdata = 0; hready = 1;

        // 1. reset and free-running counter
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
        chk("rst_cv", {31'b0, char_valid}, 32'd0);
        chk("rst_cd", {24'b0, char_data}, 32'd0);
        chk("rst_wr", wr_count, 32'd0);
        chk("rst_cc", cycle_count, 32'd0);
        chk_status("rst", 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            idle(32'h0);
            chk("cc_count", cycle_count, i);
        end

        // 6. read, hsel=0, IDLE with hsel, and non-port address are ignored
        step(1'b1, NONSEQ, 1'b0, PADDR, 32'h0, 1'b1);
        idle(32'h41);
        chk("read_cv", {31'b0, char_valid}, 32'd0);
        step(1'b0, NONSEQ, 1'b1, PADDR, 32'h0, 1'b1);
        idle(32'h42);
        chk("nosel_cv", {31'b0, char_valid}, 32'd0);
        step(1'b1, IDLE, 1'b1, PADDR, 32'h0, 1'b1);
        idle(32'h43);
        chk("idle_cv", {31'b0, char_valid}, 32'd0);
        step(1'b1, NONSEQ, 1'b1, 32'h6000_0000, 32'h0, 1'b1);
        idle(32'h44);
        chk("other_cv", {31'b0, char_valid}, 32'd0);
        chk("ignored_wr", wr_count, exp_wr);

        // 2. single print write
        step(1'b1, NONSEQ, 1'b1, PADDR, 32'h0, 1'b1);
        idle(32'h0000_0041);
        exp_wr++;
        chk("p1_cv", {31'b0, char_valid}, 32'd1);
        chk("p1_cd", {24'b0, char_data}, 32'h41);
        chk("p1_wr", wr_count, exp_wr);
        idle(32'h0);
        chk("p1_pulse_end", {31'b0, char_valid}, 32'd0);

        // 3. pipelined "OK\n" with a 2-cycle stall on the second data phase
        step(1'b1, NONSEQ, 1'b1, PADDR, 32'h0, 1'b1);
        step(1'b1, SEQ, 1'b1, PADDR, 32'h4F, 1'b1);
        chk("b1_cv", {31'b0, char_valid}, 32'd1);
        chk("b1_cd", {24'b0, char_data}, 32'h4F);
        step(1'b1, SEQ, 1'b1, PADDR, 32'h4B, 1'b0);
        chk("stall1_cv", {31'b0, char_valid}, 32'd0);
        step(1'b1, SEQ, 1'b1, PADDR, 32'h4B, 1'b0);
        chk("stall2_cv", {31'b0, char_valid}, 32'd0);
        step(1'b1, SEQ, 1'b1, PADDR, 32'h4B, 1'b1);
        chk("b2_cv", {31'b0, char_valid}, 32'd1);
        chk("b2_cd", {24'b0, char_data}, 32'h4B);
        idle(32'h0A);
        chk("b3_cv", {31'b0, char_valid}, 32'd1);
        chk("b3_cd", {24'b0, char_data}, 32'h0A);
        idle(32'h0);
        chk("b_end_cv", {31'b0, char_valid}, 32'd0);
        exp_wr += 3;
        chk("b_wr", wr_count, exp_wr);

        // byte write inside the print word decodes by word address
        step(1'b1, NONSEQ, 1'b1, PADDR + 32'd1, 32'h0, 1'b1);
        idle(32'h0000_5A00 | 32'h21);
        exp_wr++;
        chk("byte_cv", {31'b0, char_valid}, 32'd1);
        chk("byte_cd", {24'b0, char_data}, 32'h21);

        // 4. unknown control code, then PASS, then FAIL after done
        step(1'b1, NONSEQ, 1'b1, CADDR, 32'h0, 1'b1);
        idle(32'h3);
        exp_wr++;
        chk("ctrl3_wr", wr_count, exp_wr);
        chk_status("ctrl3", 0, 0, 0, 0);
        step(1'b1, NONSEQ, 1'b1, CADDR, 32'h0, 1'b1);
        idle(32'h1);
        exp_wr++;
        chk_status("pass", 1, 0, 1, 0);
        step(1'b1, NONSEQ, 1'b1, CADDR, 32'h0, 1'b1);
        idle(32'h2);
        exp_wr++;
        chk_status("late_fail", 1, 0, 1, 0);
        chk("ctrl_wr", wr_count, exp_wr);
        step(1'b1, NONSEQ, 1'b1, PADDR, 32'h0, 1'b1);
        idle(32'h2E);
        exp_wr++;
        chk("after_done_cv", {31'b0, char_valid}, 32'd1);
        chk("after_done_cd", {24'b0, char_data}, 32'h2E);
        chk("after_done_wr", wr_count, exp_wr);

        // watchdog is inert once the test has finished
        while (cyc < 105) idle(32'h0);
        chk("done_cc", cycle_count, cyc);
        chk_status("wd_after_done", 1, 0, 1, 0);

        // reset mid-transfer discards the pending data phase
        step(1'b1, NONSEQ, 1'b1, PADDR, 32'h0, 1'b1);
        hsel = 0; htrans = IDLE; hwrite = 0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_wr", wr_count, 32'd0);
        chk("async_rst_cc", cycle_count, 32'd0);
        chk_status("async_rst", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
        idle(32'h41);
        chk("rst_mid_cv", {31'b0, char_valid}, 32'd0);
        chk("rst_mid_wr", wr_count, 32'd0);

        // 5. watchdog expiry with no status write
        while (cyc < 99) idle(32'h0);
        chk("wd_cc99", cycle_count, 32'd99);
        chk_status("wd_before", 0, 0, 0, 0);
        idle(32'h0);
        chk("wd_cc100", cycle_count, 32'd100);
        chk_status("wd_fire", 0, 1, 1, 1);
        step(1'b1, NONSEQ, 1'b1, CADDR, 32'h0, 1'b1);
        idle(32'h1);
        chk_status("pass_after_tmo", 0, 1, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL tb_timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
